fft_wn_mul: RTL
===============

// Module: fft_wn_mul
// PURPOSE
//  Twiddle-multiply stage of the 64-point radix-8 DIT FFT; consumes the 7-lane twiddle bus from the twiddle generator.
//  Per beat: takes 8 complex samples plus 7 twiddles. Sample 0 passes through; sample k+1 is multiplied by twiddle lane k.
//  Results are rounded, saturated and delivered over a 3-cycle valid/ready pipeline to the next butterfly stage.
// PARAMETERS
//  DATA_WD    16  signed width of each re/im sample component
//  FFT_WN_WD  10  signed width of each twiddle component, Q1.8 format (+256 = +1.0)
//  WN_SHIFT    8  fractional bits of the twiddle; also the product right-shift
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              async active-low reset
//  din_vld       in   1              data beat valid
//  din_rdy       out  1              stage can accept a beat this cycle
//  din_re        in   8*DATA_WD      sample re, sample n at bits [n*DATA_WD +: DATA_WD]
//  din_im        in   8*DATA_WD      sample im, same packing
//  wn_vld        in   1              twiddle valid (twiddle-generator vld_out)
//  fft_wn_re     in   7*FFT_WN_WD    twiddle re, lane k at [k*FFT_WN_WD +: FFT_WN_WD]
//  fft_wn_im     in   7*FFT_WN_WD    twiddle im, same packing
//  err_clr       in   1              clears err_misalign
//  dout_vld      out  1              output beat valid
//  dout_rdy      in   1              downstream accepts
//  dout_re       out  8*DATA_WD      result re, same packing as din_re
//  dout_im       out  8*DATA_WD      result im
//  dout_last     out  1              marks the 8th beat of a group (idx 7)
//  err_misalign  out  1              sticky: din_vld != wn_vld on an accepted cycle
// BEHAVIOUR
//  - Reset (clk/rst_n: async active-low reset rst_n, clock clk): all pipeline valids, dout_*, dout_last, err_misalign, beat counter = 0.
//  - Reset mid-operation flushes all in-flight beats; no partial beats emerge after reset release.
//  - Stall: stall = dout_vld & ~dout_rdy.
//    - din_rdy = ~stall.
//    - When stall is high, every pipeline register holds.
//  - Twiddle bus has no ready: the controller holds vld/stg/idx to the generator while din_rdy = 0, so twiddles stay stable.
//  - Accept: beat accepted when din_rdy & din_vld & wn_vld.
//  - Misalign: din_rdy & (din_vld ^ wn_vld) sets err_misalign; the beat is dropped and emits no output.
//    - err_clr clears the flag; a simultaneous set wins.
//  - Latency: 3 cycles from accept to dout_vld when no stall; throughput 1 beat/cycle.
//    - S1: register ar*br, ai*bi, ar*bi, ai*br (signed, DATA_WD+FFT_WN_WD bits) per lane; register sample 0 and the lane data.
//    - S2: re = ar*br - ai*bi; im = ar*bi + ai*br (width +1); add 2^(WN_SHIFT-1); arithmetic shift right by WN_SHIFT (round half up).
//    - S3: saturate to [-2^(DATA_WD-1), 2^(DATA_WD-1)-1] and register onto dout_*.
//  - Sample 0 is delayed by 3 cycles and is never scaled or saturated.
//  - Beat counter: 3-bit, increments per accepted beat and wraps 7 -> 0.
//    - dout_last travels with the beat accepted while the counter was 7.
//    - Dropped (misaligned) beats do not increment the counter.
//  - dout_* are held stable while dout_vld & ~dout_rdy.
// CONFIGURATION
//  FFT_WN_INV_EN defined: adds input port inv (1 bit), sampled with the beat.
//    - When inv = 1, every twiddle is conjugated (im negated) before S1, giving the IFFT.
//    - Negating -512 saturates to +511.
//  FFT_WN_INV_EN undefined: no inv port; twiddles are used as received.
// STRUCTURE
//  fft_pkg holds: FFT_WN_WD, WN_SHIFT, WN_ONE=256, FFT_LANES=7, FFT_PTS=8, and the lane-slice helper functions.
//  Sub-module fft_cmul: one lane's S1-S3 complex multiply/round/saturate, with enable = ~stall.
//    - Instantiated 7 times via generate.
//  Top level holds the stall logic, the sample-0 delay line, the valid/last pipeline, the beat counter and the error flag.
// TESTING
//  1. All wn lanes = (256, 0), samples n = (n*100, -n*100) -> dout equals din exactly, 3 cycles later.
//  2. Lane 0 = (0, -256) (-j), sample 1 = (100, 50) -> dout sample 1 = (50, -100).
//  3. Lane 3 = (181, -181), sample 4 = (1, 0) -> dout sample 4 = (1, -1) (rounding check).
//  4. Lane 0 = (-256, 0), sample 1 = (-32768, -32768) -> (32767, 32767) (saturation).
//  5. Stream 8 beats with dout_rdy low for cycles 4-8 -> all 8 beats out in order.
//     - dout_last on the 8th beat only; din_rdy low while stalled; outputs held stable.
//  6. din_vld = 1, wn_vld = 0 -> err_misalign = 1, no dout_vld, counter unchanged.
//     - Then err_clr -> 0; then assert rst_n low mid-stream -> dout_vld = 0 immediately.

Source files
------------

// File: rtl/fft_wn_mul_pkg.sv
// fft_pkg: shared widths, lane counts and lane-slice / saturation helpers
// for the radix-8 twiddle-multiply stage (fft_wn_mul).
package fft_pkg;
   localparam int DATA_WD   = 16;
   localparam int FFT_WN_WD = 10;
   localparam int WN_SHIFT  = 8;
   localparam int WN_ONE    = 256;
   localparam int FFT_LANES = 7;
   localparam int FFT_PTS   = 8;
   localparam int PROD_WD   = DATA_WD + FFT_WN_WD;
   localparam int SUM_WD    = PROD_WD + 1;

   localparam logic signed [SUM_WD-1:0] SAT_MAX = SUM_WD'((2**(DATA_WD-1)) - 1);
   localparam logic signed [SUM_WD-1:0] SAT_MIN = SUM_WD'(-(2**(DATA_WD-1)));
   localparam logic signed [FFT_WN_WD-1:0] WN_MAX = FFT_WN_WD'((2**(FFT_WN_WD-1)) - 1);
   localparam logic signed [FFT_WN_WD-1:0] WN_MIN = FFT_WN_WD'(-(2**(FFT_WN_WD-1)));

   // sample n out of a packed 8-sample bus
   function automatic logic [DATA_WD-1:0] smp_slice(input logic [FFT_PTS*DATA_WD-1:0] v, input int n);
      return v[n*DATA_WD +: DATA_WD];
   endfunction

   // twiddle lane k out of a packed 7-lane bus
   function automatic logic [FFT_WN_WD-1:0] wn_slice(input logic [FFT_LANES*FFT_WN_WD-1:0] v, input int k);
      return v[k*FFT_WN_WD +: FFT_WN_WD];
   endfunction

   // negate a twiddle component; the most negative value has no positive twin
   function automatic logic [FFT_WN_WD-1:0] wn_neg_sat(input logic signed [FFT_WN_WD-1:0] x);
      return (x == WN_MIN) ? WN_MAX : -x;
   endfunction

   // clamp a rounded product sum into the sample range
   function automatic logic [DATA_WD-1:0] sat_data(input logic signed [SUM_WD-1:0] x);
      if (x > SAT_MAX) return SAT_MAX[DATA_WD-1:0];
      if (x < SAT_MIN) return SAT_MIN[DATA_WD-1:0];
      return x[DATA_WD-1:0];
   endfunction
endpackage

// File: rtl/fft_wn_mul_if.sv
// fft_wn_mul_if: data/twiddle input bus, result output bus and error flag
// of the twiddle-multiply stage. FFT_WN_INV_EN adds the inv (IFFT) bit.
interface fft_wn_mul_if;
   import fft_pkg::*;
   logic                           din_vld;
   logic                           din_rdy;
   logic [FFT_PTS*DATA_WD-1:0]     din_re;
   logic [FFT_PTS*DATA_WD-1:0]     din_im;
   logic                           wn_vld;
   logic [FFT_LANES*FFT_WN_WD-1:0] fft_wn_re;
   logic [FFT_LANES*FFT_WN_WD-1:0] fft_wn_im;
   logic                           err_clr;
   logic                           dout_vld;
   logic                           dout_rdy;
   logic [FFT_PTS*DATA_WD-1:0]     dout_re;
   logic [FFT_PTS*DATA_WD-1:0]     dout_im;
   logic                           dout_last;
   logic                           err_misalign;
`ifdef FFT_WN_INV_EN
   logic                           inv;
`endif

   modport slave (
`ifdef FFT_WN_INV_EN
      input  inv,
`endif
      input  din_vld, din_re, din_im, wn_vld, fft_wn_re, fft_wn_im, err_clr, dout_rdy,
      output din_rdy, dout_vld, dout_re, dout_im, dout_last, err_misalign
   );

   modport master (
`ifdef FFT_WN_INV_EN
      output inv,
`endif
      output din_vld, din_re, din_im, wn_vld, fft_wn_re, fft_wn_im, err_clr, dout_rdy,
      input  din_rdy, dout_vld, dout_re, dout_im, dout_last, err_misalign
   );
endinterface

// File: rtl/fft_wn_mul_cmul.sv
// fft_cmul: one lane of complex multiply (S1), round half up (S2) and
// saturate (S3). All stages advance only while i_en is high.
module fft_cmul
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic [DATA_WD-1:0]   i_ar,
   input  logic [DATA_WD-1:0]   i_ai,
   input  logic [FFT_WN_WD-1:0] i_br,
   input  logic [FFT_WN_WD-1:0] i_bi,
   output logic [DATA_WD-1:0]   o_re,
   output logic [DATA_WD-1:0]   o_im
);
   localparam int RND_HALF = 1 << (WN_SHIFT - 1);

   logic signed [PROD_WD-1:0] r_rr, r_ii, r_ri, r_ir;
   logic signed [SUM_WD-1:0]  r_re_s2, r_im_s2;
   logic signed [SUM_WD-1:0]  w_re_sum, w_im_sum;

   // rounding offset folded into the combine so S2 is one add tree
   assign w_re_sum = SUM_WD'(r_rr) - SUM_WD'(r_ii) + SUM_WD'(RND_HALF);
   assign w_im_sum = SUM_WD'(r_ri) + SUM_WD'(r_ir) + SUM_WD'(RND_HALF);

   // S1..S3 lane pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr    <= '0;
         r_ii    <= '0;
         r_ri    <= '0;
         r_ir    <= '0;
         r_re_s2 <= '0;
         r_im_s2 <= '0;
         o_re    <= '0;
         o_im    <= '0;
      end else if (i_en) begin
         r_rr    <= PROD_WD'(signed'(i_ar)) * PROD_WD'(signed'(i_br));
         r_ii    <= PROD_WD'(signed'(i_ai)) * PROD_WD'(signed'(i_bi));
         r_ri    <= PROD_WD'(signed'(i_ar)) * PROD_WD'(signed'(i_bi));
         r_ir    <= PROD_WD'(signed'(i_ai)) * PROD_WD'(signed'(i_br));
         r_re_s2 <= w_re_sum >>> WN_SHIFT;
         r_im_s2 <= w_im_sum >>> WN_SHIFT;
         o_re    <= sat_data(r_re_s2);
         o_im    <= sat_data(r_im_s2);
      end
   end
endmodule

// File: rtl/fft_wn_mul.sv
// fft_wn_mul: twiddle-multiply stage of the 64-point radix-8 DIT FFT.
// Sample 0 passes through a 3-deep delay line; samples 1..7 go through
// fft_cmul lanes. Optional macro FFT_WN_INV_EN conjugates twiddles (IFFT).
module fft_wn_mul
   import fft_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   fft_wn_mul_if.slave bus
);
   logic w_stall, w_en, w_acc, w_mis;
   logic [2:0]                          r_cnt;
   logic [3:1]                          r_vld_pipe;
   logic [3:1]                          r_last_pipe;
   logic [3:1][DATA_WD-1:0]             r_s0_re, r_s0_im;
   logic                                r_err;
   logic [FFT_LANES-1:0][FFT_WN_WD-1:0] w_wn_re, w_wn_im;
   logic [FFT_LANES-1:0][DATA_WD-1:0]   w_res_re, w_res_im;

   // a held output beat freezes the whole pipe and back-pressures the input
   assign w_stall = r_vld_pipe[3] & ~bus.dout_rdy;
   assign w_en    = ~w_stall;
   assign w_acc   = w_en & bus.din_vld & bus.wn_vld;
   assign w_mis   = w_en & (bus.din_vld ^ bus.wn_vld);

   assign bus.din_rdy      = w_en;
   assign bus.dout_vld     = r_vld_pipe[3];
   assign bus.dout_last    = r_last_pipe[3];
   assign bus.dout_re      = {w_res_re, r_s0_re[3]};
   assign bus.dout_im      = {w_res_im, r_s0_im[3]};
   assign bus.err_misalign = r_err;

   genvar k;
   generate
      for (k = 0; k < FFT_LANES; k++) begin : g_lane
         assign w_wn_re[k] = wn_slice(bus.fft_wn_re, k);
`ifdef FFT_WN_INV_EN
         assign w_wn_im[k] = bus.inv ? wn_neg_sat(wn_slice(bus.fft_wn_im, k))
                                     : wn_slice(bus.fft_wn_im, k);
`else
         assign w_wn_im[k] = wn_slice(bus.fft_wn_im, k);
`endif
         fft_cmul u_cmul (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_en),
            .i_ar  (smp_slice(bus.din_re, k + 1)),
            .i_ai  (smp_slice(bus.din_im, k + 1)),
            .i_br  (w_wn_re[k]),
            .i_bi  (w_wn_im[k]),
            .o_re  (w_res_re[k]),
            .o_im  (w_res_im[k])
         );
      end
   endgenerate

   // valid/last/sample-0 pipe, aligned with the cmul lanes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
         r_s0_re     <= '0;
         r_s0_im     <= '0;
      end else if (w_en) begin
         r_vld_pipe  <= {r_vld_pipe[2:1], w_acc};
         r_last_pipe <= {r_last_pipe[2:1], w_acc & (r_cnt == 3'd7)};
         r_s0_re     <= {r_s0_re[2:1], smp_slice(bus.din_re, 0)};
         r_s0_im     <= {r_s0_im[2:1], smp_slice(bus.din_im, 0)};
      end
   end

   // beat-in-group counter; dropped beats leave it alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_cnt <= '0;
      else if (w_acc) r_cnt <= r_cnt + 3'd1;
   end

   // sticky misalign flag; a new set beats a clear in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_err <= 1'b0;
      else if (w_mis)        r_err <= 1'b1;
      else if (bus.err_clr)  r_err <= 1'b0;
   end
endmodule
